cfg_chain_loader: RTL and testbench

Parametrised successor to the single-shot serial configuration chain and the 4-way output select in the chip top. It shifts a WIDTH-bit configuration frame in serially and checks the frame length. A good frame is committed atomically to a shadow register. The committed word can be captured back into the chain for serial readback. An N-channel registered output mux is gated until a valid configuration exists. Sits between the pad-level inputs and the measurement macros (DLL, ADC, delay line), replacing the raw shift register and mux.

---
 rtl/cfg_chain_loader.sv | 141 ++++++++++++++
 tb/tb_cfg_chain_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain loader: shifts a WIDTH-bit frame in, checks its length,
// commits good frames to a shadow register, supports readback, and gates an N-way output mux.
module cfg_chain_loader #(
  parameter int unsigned WIDTH  = 79,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned OUT_W  = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 2),
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic                    sdi,
  input  logic                    capture,
  output logic                    sdo,
  output logic [WIDTH-1:0]        cfg,
  output logic                    cfg_valid,
  output logic                    load_ok,
  output logic                    load_err,
  output logic                    busy,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*OUT_W-1:0] ch_in,
  output logic [OUT_W-1:0]        mux_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] chain, chain_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] cfg_nxt;
  logic             cfg_valid_nxt;
  logic             load_ok_nxt;
  logic             load_err_nxt;
  logic [OUT_W-1:0] mux_sel_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      chain     <= '0;
      cnt       <= '0;
      cfg       <= '0;
      cfg_valid <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      chain     <= chain_nxt;
      cnt       <= cnt_nxt;
      cfg       <= cfg_nxt;
      cfg_valid <= cfg_valid_nxt;
      load_ok   <= load_ok_nxt;
      load_err  <= load_err_nxt;
    end
  end

  // Next-state logic; the chain shifts whenever shift_en is high, in any state
  always_comb begin
    state_nxt     = state;
    chain_nxt     = chain;
    cnt_nxt       = cnt;
    cfg_nxt       = cfg;
    cfg_valid_nxt = cfg_valid;
    load_ok_nxt   = 1'b0;
    load_err_nxt  = 1'b0;

    if (shift_en) begin
      chain_nxt = {chain[WIDTH-2:0], sdi};
    end

    case (state)
      ST_IDLE: begin
        if (shift_en) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = CNT_ONE;
        end else if (capture) begin
          chain_nxt = cfg;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt != CNT_SAT) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // cfg takes the pre-shift chain; a bit shifted now opens the next frame
        if (cnt == CNT_FULL) begin
          cfg_nxt       = chain;
          cfg_valid_nxt = 1'b1;
          load_ok_nxt   = 1'b1;
        end else begin
          load_err_nxt  = 1'b1;
        end
        if (shift_en) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Channel select; out-of-range select leaves zero
  always_comb begin
    mux_sel_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        mux_sel_c = ch_in[k*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_out <= '0;
    end else begin
      mux_out <= cfg_valid ? mux_sel_c : '0;
    end
  end

  assign sdo  = chain[WIDTH-1];
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: frame outcomes are predicted from run lengths of
// shift_en and compared when load_ok/load_err pulse; the mux is checked every cycle.
module tb_cfg_chain_loader;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int OUT_W  = 8;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    shift_en;
  logic                    sdi;
  logic                    capture;
  logic                    sdo;
  logic [WIDTH-1:0]        cfg;
  logic                    cfg_valid;
  logic                    load_ok;
  logic                    load_err;
  logic                    busy;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*OUT_W-1:0] ch_in;
  logic [OUT_W-1:0]        mux_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit               ok;
    logic [WIDTH-1:0] word;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] fw;
  int               flen;
  logic [WIDTH-1:0] model_cfg;
  bit               model_valid;

  bit                      prev_ok;
  bit                      prev_valid;
  logic [SEL_W-1:0]        prev_sel;
  logic [NUM_CH*OUT_W-1:0] prev_ch;

  cfg_chain_loader #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .sdi(sdi), .capture(capture),
    .sdo(sdo), .cfg(cfg), .cfg_valid(cfg_valid), .load_ok(load_ok), .load_err(load_err),
    .busy(busy), .sel(sel), .ch_in(ch_in), .mux_out(mux_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; a frame is a run of shift_en=1 cycles ended by shift_en=0
  task automatic step(input logic se, input logic d, input logic cap);
    exp_t e;
    shift_en = se;
    sdi      = d;
    capture  = cap;
    if (se) begin
      fw = {fw[WIDTH-2:0], d};
      flen++;
    end else if (flen > 0) begin
      e.due = cyc + 2;
      if (flen == WIDTH) begin
        e.ok      = 1'b1;
        e.word    = fw;
        model_cfg = fw;
      end else begin
        e.ok   = 1'b0;
        e.word = model_cfg;
      end
      exp_q.push_back(e);
      flen = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops expected frame outcomes on pulses and checks the mux every cycle
  always @(negedge clk) begin
    exp_t             e;
    logic [OUT_W-1:0] m;
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) begin
        m = prev_valid ? prev_ch[prev_sel*OUT_W +: OUT_W] : '0;
        chk("mux_out", mux_out, m);
      end
      if (load_ok || load_err) begin
        chk("pulse_excl", load_ok & load_err, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {load_ok, load_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", load_ok, e.ok);
          chk("pulse_cycle", cyc, e.due);
          chk("cfg_at_pulse", cfg, e.word);
          if (e.ok) model_valid = 1'b1;
          chk("cfg_valid", cfg_valid, model_valid);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("pulse_missing", {load_ok, load_err}, e.ok ? 2 : 1);
      end
      prev_ok    = 1'b1;
      prev_valid = model_valid;
      prev_sel   = sel;
      prev_ch    = ch_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int               busy_n;
    logic [WIDTH-1:0] w;
    rst = 1'b1; shift_en = 1'b0; sdi = 1'b0; capture = 1'b0;
    sel = '0; ch_in = '0;
    fw = '0; flen = 0; model_cfg = '0; model_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg", cfg, 0);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mux", mux_out, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_pulses", {load_ok, load_err}, 0);
    rst = 1'b0;

    // Mux gated before any commit
    ch_in = {8'h44, 8'hC3, 8'h22, 8'h11};
    sel   = 2'd2;
    idle(2);
    chk("mux_pre_commit", mux_out, 0);

    // Good frame 8'hB2, busy for WIDTH+1 cycles
    busy_n = 0;
    w = 8'hB2;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0);
      busy_n += int'(busy);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      busy_n += int'(busy);
    end
    chk("busy_cycles", busy_n, WIDTH + 1);
    chk("good_cfg", cfg, 8'hB2);
    chk("good_cfg_valid", cfg_valid, 1);

    // Short and long frames rejected
    frame(16'h0055, 7);
    idle(3);
    frame(16'h01A3, 9);
    idle(3);
    chk("bad_len_cfg", cfg, 8'hB2);
    chk("bad_len_valid", cfg_valid, 1);

    // Back-to-back frames separated only by the COMMIT cycle
    frame(16'h00E7, 8);
    step(1'b0, 1'b0, 1'b0);
    frame(16'h005A, 8);
    idle(3);
    chk("b2b_cfg", cfg, 8'h5A);

    // Readback through capture with sdi looped from sdo
    frame(16'h00B2, 8);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      chk("readback_sdo", sdo, model_cfg[WIDTH-1-i]);
      step(1'b1, sdo, 1'b0);
    end
    idle(3);
    chk("readback_cfg", cfg, 8'hB2);

    // capture together with shift_en: shift wins
    w = 8'hC5;
    step(1'b1, w[WIDTH-1], 1'b1);
    for (int i = WIDTH - 2; i >= 0; i--) step(1'b1, w[i], 1'b0);
    idle(3);
    chk("cap_ignored_cfg", cfg, 8'hC5);

    // Mux after commit, one-cycle latency on select change
    ch_in = {8'h44, 8'hC3, 8'h22, 8'h11};
    sel   = 2'd2;
    idle(1);
    chk("mux_ch2", mux_out, 8'hC3);
    sel = 2'd0;
    idle(1);
    chk("mux_ch0", mux_out, 8'h11);

    // Randomized frames with random mux traffic
    for (int f = 0; f < 30; f++) begin
      int n;
      int g;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 11)) : WIDTH;
      g = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        sel   = SEL_W'($urandom_range(0, NUM_CH - 1));
        ch_in = $urandom;
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < g; i++) begin
        sel   = SEL_W'($urandom_range(0, NUM_CH - 1));
        ch_in = $urandom;
        step(1'b0, 1'b0, 1'b0);
      end
    end
    idle(3);

    // Asynchronous reset in the middle of a frame
    frame(16'h0005, 3);
    #2;
    rst = 1'b1;
    shift_en = 1'b0;
    flen = 0;
    exp_q.delete();
    model_cfg = '0;
    model_valid = 1'b0;
    #1;
    chk("midrst_cfg", cfg, 0);
    chk("midrst_cfg_valid", cfg_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mux", mux_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    frame(16'h00A5, 8);
    idle(4);
    chk("post_rst_cfg", cfg, 8'hA5);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
